// File: rtl/imm_ext_arbiter.sv
// imm_ext_arbiter
//   Shared immediate-extension unit. Two requesters (0 = decode, 1 = branch/jump
//   target unit) submit 16-bit immediates. A round-robin arbiter picks one per
//   cycle, the winner's immediate is extended to 32 bits (SEXT/ZEXT/LUI/BOFS),
//   and the result is held with the requester ID in a one-entry output buffer
//   under a valid/ready handshake.
//
// Ports:
//   clk_i, rst_i                     clock, asynchronous active-high reset
//   reqN_valid_i / reqN_ready_o      requester N handshake (N = 0, 1)
//   reqN_imm_i [15:0]                requester N immediate
//   reqN_mode_i [1:0]                requester N extension mode
//   rsp_valid_o / rsp_ready_i        output buffer handshake
//   rsp_data_o [31:0], rsp_id_o      extended immediate and producing requester
//   grant_cnt0_o, grant_cnt1_o       per-requester grant counters (16 bit, wrap),
//                                    present only when IMM_EXT_ARB_STATS_EN is defined
//
// Optional feature macro: IMM_EXT_ARB_STATS_EN
module imm_ext_arbiter #(
  parameter int OUT_W = 32,
  parameter int IMM_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [IMM_W-1:0] req0_imm_i,
  input  logic [1:0]       req0_mode_i,
  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [IMM_W-1:0] req1_imm_i,
  input  logic [1:0]       req1_mode_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [OUT_W-1:0] rsp_data_o,
  output logic             rsp_id_o
`ifdef IMM_EXT_ARB_STATS_EN
  ,
  output logic [15:0]      grant_cnt0_o,
  output logic [15:0]      grant_cnt1_o
`endif
);

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_t;

  buf_state_t       state_r;
  buf_state_t       state_nxt_s;
  logic             rr_ptr_r;
  logic [OUT_W-1:0] data_r;
  logic             id_r;

  logic             cand_valid_s;
  logic             cand_id_s;
  logic             can_accept_s;
  logic             grant_s;
  logic [IMM_W-1:0] sel_imm_s;
  logic [1:0]       sel_mode_s;

  // Extend a 16-bit immediate to 32 bits according to the mode encoding.
  function automatic logic [OUT_W-1:0] ext_imm(input logic [IMM_W-1:0] imm,
                                               input logic [1:0]       mode);
    logic [OUT_W-1:0] res;
    case (mode)
      2'b00:   res = {{16{imm[15]}}, imm};
      2'b01:   res = {16'h0000, imm};
      2'b10:   res = {imm, 16'h0000};
      2'b11:   res = {{14{imm[15]}}, imm, 2'b00};
      default: res = 32'h0000_0000;
    endcase
    return res;
  endfunction

  // Arbitration: candidate selection, accept condition, ready outputs and payload mux.
  always_comb begin
    cand_valid_s = 1'b0;
    cand_id_s    = 1'b0;
    if (req0_valid_i && req1_valid_i) begin
      cand_valid_s = 1'b1;
      cand_id_s    = rr_ptr_r;
    end else if (req0_valid_i) begin
      cand_valid_s = 1'b1;
      cand_id_s    = 1'b0;
    end else if (req1_valid_i) begin
      cand_valid_s = 1'b1;
      cand_id_s    = 1'b1;
    end else begin
      cand_valid_s = 1'b0;
      cand_id_s    = 1'b0;
    end

    can_accept_s = (state_r == BUF_EMPTY) || rsp_ready_i;
    // Readies are forced low while reset is held so nothing is handed off then.
    grant_s      = cand_valid_s && can_accept_s && !rst_i;
    req0_ready_o = grant_s && (cand_id_s == 1'b0);
    req1_ready_o = grant_s && (cand_id_s == 1'b1);

    if (cand_id_s) begin
      sel_imm_s  = req1_imm_i;
      sel_mode_s = req1_mode_i;
    end else begin
      sel_imm_s  = req0_imm_i;
      sel_mode_s = req0_mode_i;
    end
  end

  // Output buffer next-state: a grant always (re)fills, a bare consume empties.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      BUF_EMPTY: begin
        if (grant_s) state_nxt_s = BUF_FULL;
        else         state_nxt_s = BUF_EMPTY;
      end
      BUF_FULL: begin
        if (grant_s)          state_nxt_s = BUF_FULL;
        else if (rsp_ready_i) state_nxt_s = BUF_EMPTY;
        else                  state_nxt_s = BUF_FULL;
      end
      default: state_nxt_s = BUF_EMPTY;
    endcase
  end

  // Buffer state, payload and round-robin pointer registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r  <= BUF_EMPTY;
      data_r   <= 32'h0000_0000;
      id_r     <= 1'b0;
      rr_ptr_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (grant_s) begin
        data_r   <= ext_imm(sel_imm_s, sel_mode_s);
        id_r     <= cand_id_s;
        // Priority passes to the requester that just lost (or was absent).
        rr_ptr_r <= ~cand_id_s;
      end
    end
  end

  assign rsp_valid_o = (state_r == BUF_FULL);
  assign rsp_data_o  = data_r;
  assign rsp_id_o    = id_r;

`ifdef IMM_EXT_ARB_STATS_EN
  logic [15:0] cnt0_r;
  logic [15:0] cnt1_r;

  // Per-requester grant counters; natural 16-bit wrap.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt0_r <= 16'h0000;
      cnt1_r <= 16'h0000;
    end else begin
      if (grant_s && (cand_id_s == 1'b0)) cnt0_r <= cnt0_r + 16'd1;
      if (grant_s && (cand_id_s == 1'b1)) cnt1_r <= cnt1_r + 16'd1;
    end
  end

  assign grant_cnt0_o = cnt0_r;
  assign grant_cnt1_o = cnt1_r;
`endif

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Self-checking bench for imm_ext_arbiter. Inputs are driven 1 time unit after
// the rising edge and outputs are compared a further unit later, away from the
// edge. A behavioural model (transaction-level buffer, priority bit, integer
// arithmetic for extension) predicts readies and buffered results.
module tb_imm_ext_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        req0_valid_i = 1'b0, req1_valid_i = 1'b0;
  logic        req0_ready_o, req1_ready_o;
  logic [15:0] req0_imm_i = 16'h0, req1_imm_i = 16'h0;
  logic [1:0]  req0_mode_i = 2'b00, req1_mode_i = 2'b00;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_data_o;
  logic        rsp_id_o;
`ifdef IMM_EXT_ARB_STATS_EN
  logic [15:0] grant_cnt0_o, grant_cnt1_o;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          m_full;
  logic [31:0] m_data;
  bit          m_id;
  bit          m_ptr;
  int          m_cnt0, m_cnt1;
  int          m_last_gid;

  imm_ext_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
    .req0_imm_i(req0_imm_i), .req0_mode_i(req0_mode_i),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
    .req1_imm_i(req1_imm_i), .req1_mode_i(req1_mode_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_data_o(rsp_data_o), .rsp_id_o(rsp_id_o)
`ifdef IMM_EXT_ARB_STATS_EN
    , .grant_cnt0_o(grant_cnt0_o), .grant_cnt1_o(grant_cnt1_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // Extension computed with integer arithmetic rather than bit slicing.
  function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic [1:0] mode);
    int u, s;
    u = int'(imm);
    s = (u >= 32768) ? u - 65536 : u;
    case (mode)
      2'd0:    return 32'(s);
      2'd1:    return 32'(u);
      2'd2:    return 32'(u * 65536);
      default: return 32'(s * 4);
    endcase
  endfunction

  // Expected {ready1, ready0} for the current inputs and model state.
  function automatic logic [1:0] exp_ready();
    if (rst_i) return 2'b00;
    if (m_full && !rsp_ready_i) return 2'b00;
    if (req0_valid_i && req1_valid_i) return m_ptr ? 2'b10 : 2'b01;
    if (req0_valid_i) return 2'b01;
    if (req1_valid_i) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_reset();
    m_full = 1'b0; m_data = 32'h0; m_id = 1'b0; m_ptr = 1'b0;
    m_cnt0 = 0; m_cnt1 = 0; m_last_gid = -1;
  endtask

  task automatic drive(input logic v0, input logic [15:0] i0, input logic [1:0] md0,
                       input logic v1, input logic [15:0] i1, input logic [1:0] md1,
                       input logic rdy);
    req0_valid_i = v0; req0_imm_i = i0; req0_mode_i = md0;
    req1_valid_i = v1; req1_imm_i = i1; req1_mode_i = md1;
    rsp_ready_i  = rdy;
    #1;
  endtask

  // One clock: model follows the handshake seen just before the edge.
  task automatic tick();
    logic [1:0] g;
    g = exp_ready();
    m_last_gid = -1;
    @(posedge clk_i);
    if (rst_i) begin
      model_reset();
    end else if (g != 2'b00) begin
      m_last_gid = g[1] ? 1 : 0;
      m_data = g[1] ? ref_ext(req1_imm_i, req1_mode_i) : ref_ext(req0_imm_i, req0_mode_i);
      m_id   = g[1];
      m_full = 1'b1;
      m_ptr  = !g[1];
      if (g[1]) m_cnt1++; else m_cnt0++;
    end else if (m_full && rsp_ready_i) begin
      m_full = 1'b0;
    end
    #1;
  endtask

  task automatic apply_reset();
    rst_i = 1'b1;
    #1;
    model_reset();
    drive(1'b0, 16'h0, 2'b00, 1'b0, 16'h0, 2'b00, 1'b0);
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    model_reset();
    drive(1'b1, 16'h1111, 2'b00, 1'b1, 16'h2222, 2'b00, 1'b1);
    checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", rsp_valid_o); end
    checks++; if (rsp_data_o !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 00000000", rsp_data_o); end
    checks++; if (rsp_id_o !== 1'b0) begin errors++; $display("FAIL reset_id: got %b expected 0", rsp_id_o); end
    checks++; if ({req1_ready_o, req0_ready_o} !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b expected 00", {req1_ready_o, req0_ready_o}); end
    tick();
    checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL reset_hold_valid: got %b expected 0", rsp_valid_o); end
    rst_i = 1'b0;
    drive(1'b0, 16'h0, 2'b00, 1'b0, 16'h0, 2'b00, 1'b1);
    tick();
  endtask

  task automatic test_modes();
    logic [31:0] exp_tab [4];
    exp_tab[0] = 32'hFFFF8004; exp_tab[1] = 32'h00008004;
    exp_tab[2] = 32'h80040000; exp_tab[3] = 32'hFFFE0010;
    for (int m = 0; m < 4; m++) begin
      drive(1'b1, 16'h8004, 2'(m), 1'b0, 16'h0, 2'b00, 1'b1);
      checks++; if (req0_ready_o !== 1'b1) begin errors++; $display("FAIL mode%0d_ready0: got %b expected 1", m, req0_ready_o); end
      tick();
      checks++; if (rsp_valid_o !== 1'b1) begin errors++; $display("FAIL mode%0d_valid: got %b expected 1", m, rsp_valid_o); end
      checks++; if (rsp_data_o !== exp_tab[m]) begin errors++; $display("FAIL mode%0d_data: got %h expected %h", m, rsp_data_o, exp_tab[m]); end
      checks++; if (rsp_id_o !== 1'b0) begin errors++; $display("FAIL mode%0d_id: got %b expected 0", m, rsp_id_o); end
    end
    drive(1'b0, 16'h0, 2'b00, 1'b0, 16'h0, 2'b00, 1'b1);
    tick();
    checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL modes_drain: got %b expected 0", rsp_valid_o); end
  endtask

  task automatic test_contention();
    apply_reset();
    drive(1'b1, 16'h0001, 2'b00, 1'b1, 16'h0002, 2'b00, 1'b1);
    checks++; if ({req1_ready_o, req0_ready_o} !== 2'b01) begin errors++; $display("FAIL cont_ready_first: got %b expected 01", {req1_ready_o, req0_ready_o}); end
    tick();
    checks++; if ({rsp_valid_o, rsp_id_o, rsp_data_o} !== {1'b1, 1'b0, 32'h00000001}) begin errors++; $display("FAIL cont_rsp_first: got %b/%b/%h expected 1/0/00000001", rsp_valid_o, rsp_id_o, rsp_data_o); end
    drive(1'b0, 16'h0, 2'b00, 1'b1, 16'h0002, 2'b00, 1'b1);
    checks++; if (req1_ready_o !== 1'b1) begin errors++; $display("FAIL cont_ready_second: got %b expected 1", req1_ready_o); end
    tick();
    checks++; if ({rsp_valid_o, rsp_id_o, rsp_data_o} !== {1'b1, 1'b1, 32'h00000002}) begin errors++; $display("FAIL cont_rsp_second: got %b/%b/%h expected 1/1/00000002", rsp_valid_o, rsp_id_o, rsp_data_o); end
    drive(1'b0, 16'h0, 2'b00, 1'b0, 16'h0, 2'b00, 1'b1);
    tick();
  endtask

  task automatic test_back_pressure();
    logic [31:0] exp_d;
    drive(1'b1, 16'h1234, 2'b01, 1'b0, 16'h0, 2'b00, 1'b0);
    tick();
    drive(1'b0, 16'h0, 2'b00, 1'b1, 16'hA5A5, 2'b11, 1'b0);
    for (int c = 0; c < 3; c++) begin
      checks++; if ({req1_ready_o, req0_ready_o} !== 2'b00) begin errors++; $display("FAIL bp_ready_c%0d: got %b expected 00", c, {req1_ready_o, req0_ready_o}); end
      checks++; if ({rsp_valid_o, rsp_id_o, rsp_data_o} !== {1'b1, 1'b0, 32'h00001234}) begin errors++; $display("FAIL bp_hold_c%0d: got %b/%b/%h expected 1/0/00001234", c, rsp_valid_o, rsp_id_o, rsp_data_o); end
      tick();
    end
    drive(1'b0, 16'h0, 2'b00, 1'b1, 16'hA5A5, 2'b11, 1'b1);
    checks++; if (req1_ready_o !== 1'b1) begin errors++; $display("FAIL bp_release_ready1: got %b expected 1", req1_ready_o); end
    tick();
    exp_d = ref_ext(16'hA5A5, 2'b11);
    checks++; if ({rsp_valid_o, rsp_id_o, rsp_data_o} !== {1'b1, 1'b1, exp_d}) begin errors++; $display("FAIL bp_reload: got %b/%b/%h expected 1/1/%h", rsp_valid_o, rsp_id_o, rsp_data_o, exp_d); end
    drive(1'b0, 16'h0, 2'b00, 1'b0, 16'h0, 2'b00, 1'b1);
    tick();
  endtask

  task automatic test_fairness();
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 16'($urandom), 2'($urandom), 1'b1, 16'($urandom), 2'($urandom), 1'b1);
      tick();
      checks++; if (rsp_id_o !== 1'(i % 2)) begin errors++; $display("FAIL fair_id_%0d: got %b expected %0d", i, rsp_id_o, i % 2); end
      checks++; if (rsp_data_o !== m_data) begin errors++; $display("FAIL fair_data_%0d: got %h expected %h", i, rsp_data_o, m_data); end
    end
`ifdef IMM_EXT_ARB_STATS_EN
    checks++; if ({grant_cnt0_o, grant_cnt1_o} !== {16'd4, 16'd4}) begin errors++; $display("FAIL fair_counts: got %0d/%0d expected 4/4", grant_cnt0_o, grant_cnt1_o); end
`endif
    drive(1'b0, 16'h0, 2'b00, 1'b0, 16'h0, 2'b00, 1'b1);
    tick();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    drive(1'b1, 16'h00F0, 2'b01, 1'b0, 16'h0, 2'b00, 1'b1);
    tick();
    drive(1'b0, 16'h0, 2'b00, 1'b0, 16'h0, 2'b00, 1'b0);
    tick();
    checks++; if (rsp_valid_o !== 1'b1) begin errors++; $display("FAIL rmid_pre_valid: got %b expected 1", rsp_valid_o); end
    #2;
    rst_i = 1'b1;
    #1;
    checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL rmid_async_drop: got %b expected 0", rsp_valid_o); end
    model_reset();
    tick();
    rst_i = 1'b0;
    drive(1'b1, 16'h0003, 2'b00, 1'b1, 16'h0004, 2'b00, 1'b1);
    checks++; if ({req1_ready_o, req0_ready_o} !== 2'b01) begin errors++; $display("FAIL rmid_first_ready: got %b expected 01", {req1_ready_o, req0_ready_o}); end
    tick();
    checks++; if ({rsp_id_o, rsp_data_o} !== {1'b0, 32'h00000003}) begin errors++; $display("FAIL rmid_first_rsp: got %b/%h expected 0/00000003", rsp_id_o, rsp_data_o); end
    drive(1'b0, 16'h0, 2'b00, 1'b0, 16'h0, 2'b00, 1'b1);
    tick();
  endtask

  task automatic test_random();
    logic       v0, v1;
    logic [15:0] i0, i1;
    logic [1:0]  md0, md1;
    logic [1:0]  e;
    bool_init: begin v0 = 1'b0; v1 = 1'b0; i0 = 16'h0; i1 = 16'h0; md0 = 2'b00; md1 = 2'b00; end
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      // New payload only after a handoff or while idle; otherwise hold it (or drop valid).
      if (!v0 || req0_ready_o) begin
        v0 = ($urandom_range(0, 3) != 0); i0 = 16'($urandom); md0 = 2'($urandom);
      end else if ($urandom_range(0, 9) == 0) begin
        v0 = 1'b0;
      end else begin
        v0 = 1'b1;
      end
      if (!v1 || req1_ready_o) begin
        v1 = ($urandom_range(0, 3) != 0); i1 = 16'($urandom); md1 = 2'($urandom);
      end else if ($urandom_range(0, 9) == 0) begin
        v1 = 1'b0;
      end else begin
        v1 = 1'b1;
      end
      drive(v0, i0, md0, v1, i1, md1, 1'($urandom_range(0, 2) != 0));
      e = exp_ready();
      checks++; if ({req1_ready_o, req0_ready_o} !== e) begin errors++; $display("FAIL rand_ready_c%0d: got %b expected %b", c, {req1_ready_o, req0_ready_o}, e); end
      tick();
      checks++; if (rsp_valid_o !== m_full) begin errors++; $display("FAIL rand_valid_c%0d: got %b expected %b", c, rsp_valid_o, m_full); end
      if (m_full) begin
        checks++; if ({rsp_id_o, rsp_data_o} !== {m_id, m_data}) begin errors++; $display("FAIL rand_rsp_c%0d: got %b/%h expected %b/%h", c, rsp_id_o, rsp_data_o, m_id, m_data); end
      end
`ifdef IMM_EXT_ARB_STATS_EN
      checks++; if ({grant_cnt0_o, grant_cnt1_o} !== {16'(m_cnt0), 16'(m_cnt1)}) begin errors++; $display("FAIL rand_cnt_c%0d: got %0d/%0d expected %0d/%0d", c, grant_cnt0_o, grant_cnt1_o, m_cnt0, m_cnt1); end
`endif
    end
    drive(1'b0, 16'h0, 2'b00, 1'b0, 16'h0, 2'b00, 1'b1);
    tick();
  endtask

`ifdef IMM_EXT_ARB_STATS_EN
  task automatic test_wrap();
    apply_reset();
    drive(1'b1, 16'h0042, 2'b01, 1'b0, 16'h0, 2'b00, 1'b1);
    repeat (65537) tick();
    checks++; if (grant_cnt0_o !== 16'd1) begin errors++; $display("FAIL wrap_cnt0: got %0d expected 1", grant_cnt0_o); end
    checks++; if (grant_cnt1_o !== 16'd0) begin errors++; $display("FAIL wrap_cnt1: got %0d expected 0", grant_cnt1_o); end
    checks++; if (m_cnt0 != 65537) begin errors++; $display("FAIL wrap_grants: got %0d expected 65537", m_cnt0); end
    drive(1'b0, 16'h0, 2'b00, 1'b0, 16'h0, 2'b00, 1'b1);
    tick();
  endtask
`endif

  initial begin
    #1;
    test_reset();
    test_modes();
    test_contention();
    test_back_pressure();
    test_fairness();
    test_reset_mid();
    test_random();
`ifdef IMM_EXT_ARB_STATS_EN
    test_wrap();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
